// File: rtl/pc_fetch_ctrl.sv
// PC register, next-PC select and two-state instruction fetch handshake.
// Misaligned jalr/branch/jal targets are redirected to the trap vector.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VEC   = 32'h0000_0000,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        PC_WRITE,
    input  logic [2:0]  PC_SOURCE,
    input  logic [31:0] JALR,
    input  logic [31:0] BRANCH,
    input  logic [31:0] JAL,
    input  logic [31:0] MTVEC,
    input  logic [31:0] MEPC,
    input  logic        IMEM_RDY,
    input  logic [31:0] IMEM_DATA,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    output logic [31:0] PC,
    output logic [31:0] PC_PLUS4,
    output logic [31:0] IR,
    output logic        IR_VALID,
    output logic        MISALIGN,
    output logic [31:0] MISALIGN_ADDR
);

    localparam int unsigned XLEN = 32;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   ir_q, ir_d;
    logic              mis_q, mis_d;
    logic [XLEN-1:0]   mis_addr_q, mis_addr_d;

    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   target;
    logic              checked_src;
    logic              misalign_c;

    assign pc_plus4 = pc_q + XLEN'(4);

    // Raw next-PC target; only generator-computed targets are alignment checked.
    always_comb begin
        target      = pc_plus4;
        checked_src = 1'b0;
        case (PC_SOURCE)
            3'd1: begin
                target      = JALR & ~XLEN'(1);
                checked_src = 1'b1;
            end
            3'd2: begin
                target      = BRANCH;
                checked_src = 1'b1;
            end
            3'd3: begin
                target      = JAL;
                checked_src = 1'b1;
            end
            3'd4:    target = MTVEC;
            3'd5:    target = MEPC;
            default: target = pc_plus4;
        endcase
    end

    assign misalign_c = ALIGN_CHECK && checked_src && (target[1:0] != 2'b00);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_VEC;
            ir_q       <= '0;
            mis_q      <= 1'b0;
            mis_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            mis_q      <= mis_d;
            mis_addr_q <= mis_addr_d;
        end
    end

    // FETCH waits for memory; HOLD waits for the control unit to advance.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        mis_d      = 1'b0;
        mis_addr_d = mis_addr_q;
        case (state_q)
            S_FETCH: begin
                if (IMEM_RDY) begin
                    ir_d    = IMEM_DATA;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (PC_WRITE) begin
                    state_d = S_FETCH;
                    if (misalign_c) begin
                        pc_d       = MTVEC;
                        mis_addr_d = target;
                        mis_d      = 1'b1;
                    end else begin
                        pc_d = target;
                    end
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign IMEM_REQ      = (state_q == S_FETCH);
    assign IR_VALID      = (state_q == S_HOLD);
    assign IMEM_ADDR     = pc_q;
    assign PC            = pc_q;
    assign PC_PLUS4      = pc_plus4;
    assign IR            = ir_q;
    assign MISALIGN      = mis_q;
    assign MISALIGN_ADDR = mis_addr_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl; second instance has alignment checking off.
module tb_pc_fetch_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        PC_WRITE;
    logic [2:0]  PC_SOURCE;
    logic [31:0] JALR, BRANCH, JAL, MTVEC, MEPC;
    logic        IMEM_RDY;
    logic [31:0] IMEM_DATA;

    logic        imem_req, ir_valid, misalign;
    logic [31:0] imem_addr, pc, pc_plus4, ir, misalign_addr;
    logic        na_imem_req, na_ir_valid, na_misalign;
    logic [31:0] na_imem_addr, na_pc, na_pc_plus4, na_ir, na_misalign_addr;

    int n_cmp = 0;
    int n_bad = 0;

    pc_fetch_ctrl #(.RESET_VEC(32'h0000_0000), .ALIGN_CHECK(1'b1)) dut (
        .CLK(CLK), .RST(RST), .PC_WRITE(PC_WRITE), .PC_SOURCE(PC_SOURCE),
        .JALR(JALR), .BRANCH(BRANCH), .JAL(JAL), .MTVEC(MTVEC), .MEPC(MEPC),
        .IMEM_RDY(IMEM_RDY), .IMEM_DATA(IMEM_DATA),
        .IMEM_REQ(imem_req), .IMEM_ADDR(imem_addr), .PC(pc), .PC_PLUS4(pc_plus4),
        .IR(ir), .IR_VALID(ir_valid), .MISALIGN(misalign), .MISALIGN_ADDR(misalign_addr)
    );

    pc_fetch_ctrl #(.RESET_VEC(32'h0000_0000), .ALIGN_CHECK(1'b0)) dut_na (
        .CLK(CLK), .RST(RST), .PC_WRITE(PC_WRITE), .PC_SOURCE(PC_SOURCE),
        .JALR(JALR), .BRANCH(BRANCH), .JAL(JAL), .MTVEC(MTVEC), .MEPC(MEPC),
        .IMEM_RDY(IMEM_RDY), .IMEM_DATA(IMEM_DATA),
        .IMEM_REQ(na_imem_req), .IMEM_ADDR(na_imem_addr), .PC(na_pc), .PC_PLUS4(na_pc_plus4),
        .IR(na_ir), .IR_VALID(na_ir_valid), .MISALIGN(na_misalign), .MISALIGN_ADDR(na_misalign_addr)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1ns after the rising edge; inputs change there too.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic fetch(input logic [31:0] data);
        PC_WRITE  = 1'b0;
        IMEM_RDY  = 1'b1;
        IMEM_DATA = data;
        step();
        IMEM_RDY  = 1'b0;
    endtask

    task automatic advance(input logic [2:0] src);
        PC_SOURCE = src;
        PC_WRITE  = 1'b1;
        step();
        PC_WRITE  = 1'b0;
    endtask

    initial begin
        RST = 1'b1; PC_WRITE = 1'b0; PC_SOURCE = 3'd0;
        JALR = '0; BRANCH = '0; JAL = '0; MTVEC = 32'h800; MEPC = '0;
        IMEM_RDY = 1'b0; IMEM_DATA = '0;

        // Reset values before any clock edge
        #2;
        check("rst_pc", pc, 32'h0);
        check("rst_req", 32'(imem_req), 32'd1);
        check("rst_irv", 32'(ir_valid), 32'd0);
        check("rst_ir", ir, 32'h0);
        check("rst_mis", 32'(misalign), 32'd0);
        check("rst_misaddr", misalign_addr, 32'h0);

        // Release reset with memory ready: first instruction latched
        step();
        RST = 1'b0;
        IMEM_RDY = 1'b1; IMEM_DATA = 32'h0050_0093;
        step();
        IMEM_RDY = 1'b0;
        check("first_ir", ir, 32'h0050_0093);
        check("first_irv", 32'(ir_valid), 32'd1);
        check("first_req", 32'(imem_req), 32'd0);

        // Jump away, then reset asynchronously mid-FETCH
        JAL = 32'h100;
        advance(3'd3);
        check("jal100_pc", pc, 32'h100);
        #2 RST = 1'b1;
        #1;
        check("async_pc", pc, 32'h0);
        check("async_req", 32'(imem_req), 32'd1);
        check("async_irv", 32'(ir_valid), 32'd0);
        check("async_ir", ir, 32'h0);
        RST = 1'b0;
        step();
        fetch(32'h1111_1111);
        advance(3'd3);
        fetch(32'hAAAA_0001);
        check("hold100_pc", pc, 32'h100);
        check("hold100_ir", ir, 32'hAAAA_0001);

        // Sequential advance then stalled memory; PC_WRITE ignored in FETCH
        advance(3'd0);
        check("seq_pc", pc, 32'h104);
        check("seq_req", 32'(imem_req), 32'd1);
        check("seq_addr", imem_addr, 32'h104);
        PC_WRITE = 1'b1; PC_SOURCE = 3'd3; JAL = 32'h400;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", pc, 32'h104);
            check("stall_ir", ir, 32'hAAAA_0001);
            check("stall_irv", 32'(ir_valid), 32'd0);
        end
        IMEM_RDY = 1'b1; IMEM_DATA = 32'hBBBB_0002;
        step();
        IMEM_RDY = 1'b0; PC_WRITE = 1'b0;
        check("rdy_pw_ir", ir, 32'hBBBB_0002);
        check("rdy_pw_pc", pc, 32'h104);
        check("rdy_pw_irv", 32'(ir_valid), 32'd1);

        // Memory activity in HOLD is ignored
        IMEM_RDY = 1'b1; IMEM_DATA = 32'hDEAD_BEEF;
        step();
        IMEM_RDY = 1'b0;
        check("hold_ir", ir, 32'hBBBB_0002);
        check("hold_irv", 32'(ir_valid), 32'd1);

        // Aligned targets
        JAL = 32'h200;
        advance(3'd3);
        check("jal_pc", pc, 32'h200);
        fetch(32'h0000_0013);
        JALR = 32'h305;
        advance(3'd1);
        check("jalr_pc", pc, 32'h304);
        check("jalr_mis", 32'(misalign), 32'd0);
        fetch(32'h0000_0013);
        BRANCH = 32'h0FC;
        advance(3'd2);
        check("br_pc", pc, 32'h0FC);
        fetch(32'h0000_0013);

        // Misaligned branch: redirect to MTVEC; unchecked instance takes target
        BRANCH = 32'h102; MTVEC = 32'h800;
        advance(3'd2);
        check("mis_pc", pc, 32'h800);
        check("mis_pulse", 32'(misalign), 32'd1);
        check("mis_addr", misalign_addr, 32'h102);
        check("na_pc", na_pc, 32'h102);
        check("na_pulse", 32'(na_misalign), 32'd0);
        check("na_addr", na_misalign_addr, 32'h0);
        fetch(32'h0000_0013);
        check("mis_end", 32'(misalign), 32'd0);
        check("mis_addr_hold", misalign_addr, 32'h102);

        // Misaligned jalr after bit-0 clear
        JALR = 32'h307;
        advance(3'd1);
        check("jalr_mis_pc", pc, 32'h800);
        check("jalr_mis_addr", misalign_addr, 32'h306);
        fetch(32'h0000_0013);

        // Trap return, MTVEC source, wrap and aliased select
        MEPC = 32'h104;
        advance(3'd5);
        check("mepc_pc", pc, 32'h104);
        fetch(32'h0000_0013);
        MEPC = 32'h106;
        advance(3'd5);
        check("mepc_odd_pc", pc, 32'h106);
        check("mepc_odd_mis", 32'(misalign), 32'd0);
        fetch(32'h0000_0013);
        MTVEC = 32'h880;
        advance(3'd4);
        check("mtvec_pc", pc, 32'h880);
        fetch(32'h0000_0013);
        JAL = 32'hFFFF_FFFC;
        advance(3'd3);
        check("top_pc", pc, 32'hFFFF_FFFC);
        check("top_plus4", pc_plus4, 32'h0);
        fetch(32'h0000_0013);
        advance(3'd0);
        check("wrap_pc", pc, 32'h0);
        fetch(32'h0000_0013);
        advance(3'd7);
        check("src7_pc", pc, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Sits directly downstream of the branch address generator. Selects the next PC from the generator's jal, jalr and branch targets, plus PC+4, mtvec and mepc, and holds it in the PC register. Runs a two-state fetch handshake with instruction memory and latches the returned instruction into IR. It also detects misaligned control-flow targets and redirects them to the trap vector.

Parameters:
RESET_VEC, 32'h0000_0000, PC value loaded on reset.
ALIGN_CHECK, 1, 1 = misaligned-target detection enabled; 0 = targets used as computed (bit 0 of jalr still cleared).

Ports:
CLK  input  1  system clock, rising edge.
RST  input  1  asynchronous, active-high reset.
PC_WRITE  input  1  control unit permits PC advance; honoured only in HOLD.
PC_SOURCE  input  3  next-PC select: 0 PC+4, 1 JALR, 2 BRANCH, 3 JAL, 4 MTVEC, 5 MEPC, 6/7 treated as 0.
JALR  input  32  jalr target from the branch address generator.
BRANCH  input  32  branch target from the branch address generator.
JAL  input  32  jal target from the branch address generator.
MTVEC  input  32  trap vector from the CSR file.
MEPC  input  32  return address from the CSR file.
IMEM_RDY  input  1  instruction memory has IMEM_DATA valid this cycle.
IMEM_DATA  input  32  instruction word from memory.
IMEM_REQ  output  1  fetch request; high throughout FETCH.
IMEM_ADDR  output  32  fetch address; equals PC.
PC  output  32  current PC, registered.
PC_PLUS4  output  32  PC + 4, combinational, modulo 2^32.
IR  output  32  latched instruction.
IR_VALID  output  1  IR holds the instruction at PC; high throughout HOLD.
MISALIGN  output  1  one-cycle pulse on a misaligned redirect.
MISALIGN_ADDR  output  32  offending target; holds until the next misalign or reset.

Behaviour:
- Reset (async, immediate):
  - PC=RESET_VEC, IR=0, MISALIGN=0, MISALIGN_ADDR=0.
  - State=FETCH, so IMEM_REQ=1 and IR_VALID=0 while RST is high and after it is released.
  - Reset mid-FETCH abandons the request. Reset mid-HOLD discards IR.
- State FETCH:
  - IMEM_REQ=1, IMEM_ADDR=PC.
  - When IMEM_RDY=1 at a rising edge: IR<=IMEM_DATA and state<=HOLD.
  - Otherwise stay in FETCH with PC and IR unchanged. There is no timeout.
  - PC_WRITE is ignored in FETCH.
- State HOLD:
  - IMEM_REQ=0, IR_VALID=1. IMEM_RDY and IMEM_DATA are ignored.
  - When PC_WRITE=1 at an edge: PC<=next and state<=FETCH.
  - Otherwise hold.
- Next-PC computation:
  - Raw target per PC_SOURCE.
  - For JALR, bit 0 is forced to 0 before any check.
  - All adds wrap modulo 2^32; no overflow flag.
- Misalignment (ALIGN_CHECK=1):
  - Applies to sources 1, 2 and 3 only, when target[1:0] != 2'b00 (after the jalr bit-0 clear).
  - On an accepted PC_WRITE with such a target: PC<=MTVEC (not the target), MISALIGN_ADDR<=target, MISALIGN=1 for exactly the next cycle, state<=FETCH.
  - MTVEC and MEPC are never checked; an unaligned MEPC is loaded as-is.
- Latency:
  - Minimum instruction cycle is 2 clocks: FETCH with IMEM_RDY already high, then HOLD with PC_WRITE high.
  - Each extra IMEM_RDY-low cycle adds one clock.
- Simultaneous events:
  - RST overrides everything.
  - IMEM_RDY and PC_WRITE together in FETCH: only the IR latch happens.
- PC_PLUS4 and IMEM_ADDR are combinational from the PC register; all other outputs are registered.

Test Plan:
1. Reset sequencing: assert RST mid-FETCH with RESET_VEC=0 -> PC=0, IMEM_REQ=1, IR_VALID=0 immediately without a clock edge. Release RST with IMEM_RDY=1, IMEM_DATA=32'h00500093 -> next cycle IR=32'h00500093, IR_VALID=1.
2. Sequential advance: from PC=0x100 in HOLD, PC_SOURCE=0, PC_WRITE=1 -> PC=0x104, IMEM_REQ=1. Hold IMEM_RDY low 3 cycles -> PC, IR unchanged and IR_VALID=0 throughout.
3. Targets: in HOLD, PC_SOURCE=3 with JAL=0x200 -> PC=0x200. PC_SOURCE=1 with JALR=0x305 -> PC=0x304, MISALIGN=0. PC_SOURCE=2 with BRANCH=0x0FC -> PC=0x0FC.
4. Misalign: PC_SOURCE=2, BRANCH=0x102, MTVEC=0x800, PC_WRITE=1 -> PC=0x800, MISALIGN=1 for one cycle, MISALIGN_ADDR=0x102. Repeat with ALIGN_CHECK=0 -> PC=0x102, no pulse.
5. Trap return and wrap: PC_SOURCE=5, MEPC=0x104 -> PC=0x104. From PC=0xFFFFFFFC, PC_SOURCE=0 -> PC=0x00000000. PC_SOURCE=7 -> behaves as PC+4.
6. Ignored inputs: PC_WRITE=1 in FETCH -> no PC change. IMEM_RDY=1 with new IMEM_DATA in HOLD -> IR unchanged.
